// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
package alu_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NUM_OPS = 8;
  localparam int unsigned OP_W    = 3;

  // Opcode map of the big result mux
  localparam logic [OP_W-1:0] OP_ADD    = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 3'd1;
  localparam logic [OP_W-1:0] OP_OR     = 3'd2;
  localparam logic [OP_W-1:0] OP_AND    = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd4;
  localparam logic [OP_W-1:0] OP_PASS_A = 3'd5;
  localparam logic [OP_W-1:0] OP_ILL6   = 3'd6;
  localparam logic [OP_W-1:0] OP_ILL7   = 3'd7;

  // One registered result with the flags captured alongside it
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [OP_W-1:0]  op;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } alu_res_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream/downstream handshake bundle of the ALU result stage.
interface alu_result_stage_if;
  import alu_pkg::*;

  // Upstream side
  logic                     in_valid;
  logic                     in_ready;
  logic [OP_W-1:0]          in_op;
  logic [NUM_OPS*WIDTH-1:0] mux_in;
  logic                     in_carry;
  logic                     in_ovf;

  // Downstream side
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_result;
  logic [OP_W-1:0]          out_op;
  logic                     out_zero;
  logic                     out_neg;
  logic                     out_carry;
  logic                     out_ovf;
  logic                     illegal_op;

  // Environment side: produces op results, consumes the stage output
  modport master (
    output in_valid, in_op, mux_in, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, out_neg,
           out_carry, out_ovf, illegal_op
  );

  // Stage side
  modport slave (
    input  in_valid, in_op, mux_in, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, out_neg,
           out_carry, out_ovf, illegal_op
  );

endinterface

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready buffer for alu_res_t. The main entry drives the output; the skid entry
// catches one item when the consumer stalls. in_ready depends only on registered state.
module alu_skid_buffer
  import alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  alu_res_t in_data_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output alu_res_t out_data_o
);

  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  alu_res_t main_q, main_d;
  alu_res_t skid_q, skid_d;

  logic accept;
  logic retire;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

  assign accept = in_valid_i & ~skid_valid_q;
  assign retire = main_valid_q & out_ready_i;

  // Next-state for both entries; data in an emptied entry is simply held
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    if (retire) begin
      if (skid_valid_q) begin
        // Skid full means in_ready was low, so no accept can coincide here
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        // Full-throughput case: main reloads in the same cycle it retires
        main_d = in_data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = in_data_i;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data_i;
        skid_valid_d = 1'b1;
      end
    end
  end

  // Storage registers with synchronous reset that discards both entries
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU output stage: selects one per-op result, derives flags at accept time, and hands the
// result+flags to a two-entry skid buffer. Also keeps a sticky illegal-opcode indication.
module alu_result_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_result_stage_if.slave  bus
);

  logic [WIDTH-1:0] op_slices [NUM_OPS];
  alu_res_t         res_in;
  alu_res_t         res_out;
  logic             op_illegal;
  logic             stage_ready;
  logic             accept;
  logic             illegal_q, illegal_d;

  // Split the flat mux bus into one slice per opcode
  always_comb begin
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      op_slices[k] = bus.mux_in[k*WIDTH +: WIDTH];
    end
  end

  // Big mux and flag derivation; flags are frozen here and never recomputed downstream
  always_comb begin
    res_in     = '0;
    op_illegal = 1'b0;
    res_in.op  = bus.in_op;
    unique case (bus.in_op)
      OP_ADD, OP_SUB: begin
        res_in.result = op_slices[bus.in_op];
        res_in.carry  = bus.in_carry;
        res_in.ovf    = bus.in_ovf;
      end
      OP_OR, OP_AND, OP_XOR, OP_PASS_A: begin
        res_in.result = op_slices[bus.in_op];
      end
      OP_ILL6, OP_ILL7: begin
        // Result forced to zero so the zero flag reads as set
        res_in.result = '0;
        op_illegal    = 1'b1;
      end
    endcase
    res_in.zero = (res_in.result == '0);
    res_in.neg  = res_in.result[WIDTH-1];
  end

  alu_skid_buffer u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (stage_ready),
    .in_data_i   (res_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (res_out)
  );

  assign accept = bus.in_valid & stage_ready;

  // Sticky illegal-op indication: only reset clears it
  always_comb begin
    illegal_d = illegal_q | (accept & op_illegal);
  end

  // Sticky bit register
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready   = stage_ready;
  assign bus.out_result = res_out.result;
  assign bus.out_op     = res_out.op;
  assign bus.out_zero   = res_out.zero;
  assign bus.out_neg    = res_out.neg;
  assign bus.out_carry  = res_out.carry;
  assign bus.out_ovf    = res_out.ovf;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table plus stall/stream/reset sequences,
// with a queue scoreboard checking every retired result.
module tb_alu_result_stage;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  op;
    logic        z;
    logic        n;
    logic        c;
    logic        o;
  } res_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] val;
    logic        c;
    logic        o;
    logic [15:0] eres;
    logic        ez;
    logic        en;
    logic        ec;
    logic        eo;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_retired;
  res_t sb_q[$];

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] op, input logic [127:0] m, input logic c,
                                 input logic o);
    res_t r;
    r.op     = op;
    r.result = (op > 3'd5) ? 16'h0000 : m[op*16 +: 16];
    r.c      = (op <= 3'd1) ? c : 1'b0;
    r.o      = (op <= 3'd1) ? o : 1'b0;
    r.z      = (r.result == 16'h0000);
    r.n      = r.result[15];
    return r;
  endfunction

  // Scoreboard: pop/compare on retire, push on accept; reset flushes expectations
  always @(negedge clk) begin
    res_t act;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        act = {bus.out_result, bus.out_op, bus.out_zero, bus.out_neg, bus.out_carry,
               bus.out_ovf};
        n_retired++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_output", 32'(act), 32'h3fffff);
        end else begin
          chk("sb_retire", 32'(act), 32'(sb_q[0]));
          void'(sb_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back(model(bus.in_op, bus.mux_in, bus.in_carry, bus.in_ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] val, input logic c,
                       input logic o);
    logic [127:0] m;
    for (int k = 0; k < 8; k++) m[k*16 +: 16] = 16'($urandom);
    m[op*16 +: 16] = val;
    bus.in_op    = op;
    bus.mux_in   = m;
    bus.in_carry = c;
    bus.in_ovf   = o;
    bus.in_valid = 1'b1;
  endtask

  // Holds in_valid until accepted, then drops it just after the accepting edge
  task automatic send(input logic [2:0] op, input logic [15:0] val);
    int t;
    drive(op, val, 1'b0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  vec_t vecs[10];
  logic ill_exp;
  int   base;
  logic rdy_ok;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_retired = 0;
    ill_exp   = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.mux_in    = '0;
    bus.in_carry  = 1'b0;
    bus.in_ovf    = 1'b0;
    bus.out_ready = 1'b0;

    //                op    val       c     o     eres      z     n     c     o
    vecs[0] = '{3'd3, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'd3, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'd0, 16'h8000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{3'd2, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'd1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{3'd4, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{3'd6, 16'hABCD, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3'd5, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{3'd7, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{3'd1, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    step();
    step();
    @(negedge clk);
    chk("reset_outputs",
        {8'h0, bus.out_valid, bus.in_ready, bus.out_result, bus.out_op, bus.out_zero,
         bus.out_neg, bus.out_carry, bus.out_ovf, bus.illegal_op},
        {8'h0, 1'b0, 1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    rst = 1'b0;

    // Table-driven single transfers, one-cycle latency
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op, vecs[i].val, vecs[i].c, vecs[i].o);
      if (vecs[i].op >= 3'd6) ill_exp = 1'b1;
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_result_op", i), {13'h0, bus.out_result, bus.out_op},
          {13'h0, vecs[i].eres, vecs[i].op});
      chk($sformatf("vec%0d_flags", i),
          {28'h0, bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf},
          {28'h0, vecs[i].ez, vecs[i].en, vecs[i].ec, vecs[i].eo});
      chk($sformatf("vec%0d_illegal", i), 32'(bus.illegal_op), 32'(ill_exp));
      step();
    end

    // Stall: A in main, B in skid, C held off until space frees
    bus.out_ready = 1'b0;
    base = n_retired;
    send(3'd3, 16'hAAAA);
    send(3'd3, 16'hBBBB);
    fork
      send(3'd3, 16'hCCCC);
      begin
        step();
        step();
        @(negedge clk);
        chk("stall_hold", {11'h0, bus.out_valid, bus.in_ready, bus.out_result, bus.out_op},
            {11'h0, 1'b1, 1'b0, 16'hAAAA, 3'd3});
        step();
        bus.out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
    step();
    chk("stall_drain_count", 32'(n_retired - base), 32'd3);
    chk("stall_sb_empty", 32'(sb_q.size()), 32'd0);

    // Back-to-back stream: one result per cycle
    base   = n_retired;
    rdy_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(3'(i % 6), 16'($urandom), 1'($urandom), 1'($urandom));
      step();
      if (!bus.in_ready) rdy_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_ready_high", 32'(rdy_ok), 32'd1);
    chk("stream_count", 32'(n_retired - base), 32'd16);
    chk("stream_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while both entries are full
    bus.out_ready = 1'b0;
    send(3'd2, 16'h1111);
    send(3'd4, 16'h2222);
    @(negedge clk);
    chk("prereset_full", {30'h0, bus.out_valid, bus.in_ready}, {30'h0, 1'b1, 1'b0});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_state",
        {9'h0, bus.out_valid, bus.in_ready, bus.illegal_op, bus.out_result, bus.out_op},
        {9'h0, 1'b0, 1'b1, 1'b0, 16'h0, 3'd0});
    step();
    chk("midreset_no_output", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
